// File: rtl/bp_cce_serial_splitter.sv
// Splits one wide coherence command into narrow beats and reassembles the
// narrow responses into a single wide response, one transaction at a time.
module bp_cce_serial_splitter #(
  parameter int paddr_width_p    = 40,
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 32,
  parameter int hdr_width_p      = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [hdr_width_p-1:0]      in_cmd_hdr_i,
  input  logic [paddr_width_p-1:0]    in_cmd_addr_i,
  input  logic [2:0]                  in_cmd_size_i,
  input  logic [in_data_width_p-1:0]  in_cmd_data_i,
  input  logic                        in_cmd_v_i,
  output logic                        in_cmd_ready_o,

  output logic [hdr_width_p-1:0]      out_cmd_hdr_o,
  output logic [paddr_width_p-1:0]    out_cmd_addr_o,
  output logic [2:0]                  out_cmd_size_o,
  output logic [out_data_width_p-1:0] out_cmd_data_o,
  output logic                        out_cmd_v_o,
  input  logic                        out_cmd_ready_i,

  input  logic [out_data_width_p-1:0] out_resp_data_i,
  input  logic                        out_resp_v_i,
  output logic                        out_resp_yumi_o,

  output logic [hdr_width_p-1:0]      in_resp_hdr_o,
  output logic [paddr_width_p-1:0]    in_resp_addr_o,
  output logic [2:0]                  in_resp_size_o,
  output logic [in_data_width_p-1:0]  in_resp_data_o,
  output logic                        in_resp_v_o,
  input  logic                        in_resp_yumi_i
);

  localparam int beats_lp    = in_data_width_p / out_data_width_p;
  localparam int out_size_lp = $clog2(out_data_width_p / 8);
  localparam int in_size_lp  = $clog2(in_data_width_p / 8);
  localparam int cnt_w_lp    = $clog2(beats_lp) + 1;
  localparam int idx_w_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  typedef enum logic [1:0] {e_idle, e_busy, e_done} state_e;

  state_e state_q, state_d;

  logic [hdr_width_p-1:0]                   hdr_q;
  logic [paddr_width_p-1:0]                 addr_q;
  logic [2:0]                               size_q;
  logic [beats_lp-1:0][out_data_width_p-1:0] data_q;
  logic [beats_lp-1:0][out_data_width_p-1:0] resp_q, resp_d;

  logic [cnt_w_lp-1:0] n_q, n_d;
  logic [cnt_w_lp-1:0] sent_q, sent_d;
  logic [cnt_w_lp-1:0] recv_q, recv_d;

  logic                accept;
  logic                send;
  logic                recv;
  logic [2:0]          size_clamped;
  logic [cnt_w_lp-1:0] n_calc;
  logic [idx_w_lp-1:0] sent_idx;
  logic [idx_w_lp-1:0] recv_idx;

  assign accept   = in_cmd_ready_o & in_cmd_v_i;
  assign send     = out_cmd_v_o & out_cmd_ready_i;
  assign recv     = out_resp_yumi_o;
  assign sent_idx = sent_q[idx_w_lp-1:0];
  assign recv_idx = recv_q[idx_w_lp-1:0];

  // Oversized requests are clamped to the wide width; anything that fits in
  // one narrow beat needs exactly one beat.
  always_comb begin
    size_clamped = (in_cmd_size_i > 3'(in_size_lp)) ? 3'(in_size_lp) : in_cmd_size_i;
    if (size_clamped <= 3'(out_size_lp)) begin
      n_calc = cnt_w_lp'(1);
    end else begin
      n_calc = cnt_w_lp'(1) << (size_clamped - 3'(out_size_lp));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      n_q     <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      hdr_q  <= in_cmd_hdr_i;
      addr_q <= in_cmd_addr_i;
      size_q <= size_clamped;
      data_q <= in_cmd_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle:  if (accept) state_d = e_busy;
      e_busy:  if (recv_q == n_q) state_d = e_done;
      e_done:  if (in_resp_yumi_i) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  always_comb begin
    in_cmd_ready_o  = 1'b0;
    out_cmd_v_o     = 1'b0;
    out_resp_yumi_o = 1'b0;
    in_resp_v_o     = 1'b0;
    case (state_q)
      e_idle:  in_cmd_ready_o = reset_n_i;
      e_busy: begin
        out_cmd_v_o     = (sent_q < n_q);
        out_resp_yumi_o = out_resp_v_i & (recv_q < sent_q);
      end
      e_done:  in_resp_v_o = 1'b1;
      default: ;
    endcase
  end

  // Sends and response collection run concurrently; both counters may step
  // in the same cycle.
  always_comb begin
    n_d    = n_q;
    sent_d = sent_q;
    recv_d = recv_q;
    resp_d = resp_q;
    if (accept) begin
      n_d    = n_calc;
      sent_d = '0;
      recv_d = '0;
    end
    if (send) begin
      sent_d = sent_q + cnt_w_lp'(1);
    end
    if (recv) begin
      recv_d = recv_q + cnt_w_lp'(1);
      if (n_q == cnt_w_lp'(1)) begin
        for (int k = 0; k < beats_lp; k++) begin
          resp_d[k] = out_resp_data_i;
        end
      end else begin
        resp_d[recv_idx] = out_resp_data_i;
      end
    end
  end

  assign out_cmd_hdr_o  = hdr_q;
  assign out_cmd_addr_o = addr_q + (paddr_width_p'(sent_q) << out_size_lp);
  assign out_cmd_size_o = (size_q > 3'(out_size_lp)) ? 3'(out_size_lp) : size_q;
  assign out_cmd_data_o = data_q[sent_idx];

  assign in_resp_hdr_o  = hdr_q;
  assign in_resp_addr_o = addr_q;
  assign in_resp_size_o = size_q;
  assign in_resp_data_o = resp_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && accept && (in_cmd_size_i > 3'(in_size_lp))) begin
      $error("bp_cce_serial_splitter: command size %0d exceeds wide width, clamped",
             in_cmd_size_i);
    end
    if (reset_n_i && out_resp_v_i && (state_q != e_busy)) begin
      $error("bp_cce_serial_splitter: response presented with no outstanding command");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cce_serial_splitter.sv
// Scoreboard bench for bp_cce_serial_splitter: a 64->32 instance for the
// main vectors and a 128->32 instance for the four-beat case.
module tb_bp_cce_serial_splitter;

  typedef struct {
    logic [15:0]  hdr;
    logic [39:0]  addr;
    logic [2:0]   size;
    logic [31:0]  data;
  } beat_t;

  typedef struct {
    logic [15:0]  hdr;
    logic [39:0]  addr;
    logic [2:0]   size;
    logic [127:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;

  initial forever #5 clk = ~clk;

  // 64 -> 32 instance
  logic [15:0] in_cmd_hdr_i;
  logic [39:0] in_cmd_addr_i;
  logic [2:0]  in_cmd_size_i;
  logic [63:0] in_cmd_data_i;
  logic        in_cmd_v_i, in_cmd_ready_o;
  logic [15:0] out_cmd_hdr_o;
  logic [39:0] out_cmd_addr_o;
  logic [2:0]  out_cmd_size_o;
  logic [31:0] out_cmd_data_o;
  logic        out_cmd_v_o, out_cmd_ready_i;
  logic [31:0] out_resp_data_i;
  logic        out_resp_v_i, out_resp_yumi_o;
  logic [15:0] in_resp_hdr_o;
  logic [39:0] in_resp_addr_o;
  logic [2:0]  in_resp_size_o;
  logic [63:0] in_resp_data_o;
  logic        in_resp_v_o, in_resp_yumi_i;

  // 128 -> 32 instance
  logic [15:0]  w_in_cmd_hdr_i;
  logic [39:0]  w_in_cmd_addr_i;
  logic [2:0]   w_in_cmd_size_i;
  logic [127:0] w_in_cmd_data_i;
  logic         w_in_cmd_v_i, w_in_cmd_ready_o;
  logic [15:0]  w_out_cmd_hdr_o;
  logic [39:0]  w_out_cmd_addr_o;
  logic [2:0]   w_out_cmd_size_o;
  logic [31:0]  w_out_cmd_data_o;
  logic         w_out_cmd_v_o, w_out_cmd_ready_i;
  logic [31:0]  w_out_resp_data_i;
  logic         w_out_resp_v_i, w_out_resp_yumi_o;
  logic [15:0]  w_in_resp_hdr_o;
  logic [39:0]  w_in_resp_addr_o;
  logic [2:0]   w_in_resp_size_o;
  logic [127:0] w_in_resp_data_o;
  logic         w_in_resp_v_o, w_in_resp_yumi_i;

  bp_cce_serial_splitter #(
    .paddr_width_p(40), .in_data_width_p(64), .out_data_width_p(32), .hdr_width_p(16)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .in_cmd_hdr_i(in_cmd_hdr_i), .in_cmd_addr_i(in_cmd_addr_i),
    .in_cmd_size_i(in_cmd_size_i), .in_cmd_data_i(in_cmd_data_i),
    .in_cmd_v_i(in_cmd_v_i), .in_cmd_ready_o(in_cmd_ready_o),
    .out_cmd_hdr_o(out_cmd_hdr_o), .out_cmd_addr_o(out_cmd_addr_o),
    .out_cmd_size_o(out_cmd_size_o), .out_cmd_data_o(out_cmd_data_o),
    .out_cmd_v_o(out_cmd_v_o), .out_cmd_ready_i(out_cmd_ready_i),
    .out_resp_data_i(out_resp_data_i), .out_resp_v_i(out_resp_v_i),
    .out_resp_yumi_o(out_resp_yumi_o),
    .in_resp_hdr_o(in_resp_hdr_o), .in_resp_addr_o(in_resp_addr_o),
    .in_resp_size_o(in_resp_size_o), .in_resp_data_o(in_resp_data_o),
    .in_resp_v_o(in_resp_v_o), .in_resp_yumi_i(in_resp_yumi_i)
  );

  bp_cce_serial_splitter #(
    .paddr_width_p(40), .in_data_width_p(128), .out_data_width_p(32), .hdr_width_p(16)
  ) dut_w (
    .clk_i(clk), .reset_n_i(rst_n),
    .in_cmd_hdr_i(w_in_cmd_hdr_i), .in_cmd_addr_i(w_in_cmd_addr_i),
    .in_cmd_size_i(w_in_cmd_size_i), .in_cmd_data_i(w_in_cmd_data_i),
    .in_cmd_v_i(w_in_cmd_v_i), .in_cmd_ready_o(w_in_cmd_ready_o),
    .out_cmd_hdr_o(w_out_cmd_hdr_o), .out_cmd_addr_o(w_out_cmd_addr_o),
    .out_cmd_size_o(w_out_cmd_size_o), .out_cmd_data_o(w_out_cmd_data_o),
    .out_cmd_v_o(w_out_cmd_v_o), .out_cmd_ready_i(w_out_cmd_ready_i),
    .out_resp_data_i(w_out_resp_data_i), .out_resp_v_i(w_out_resp_v_i),
    .out_resp_yumi_o(w_out_resp_yumi_o),
    .in_resp_hdr_o(w_in_resp_hdr_o), .in_resp_addr_o(w_in_resp_addr_o),
    .in_resp_size_o(w_in_resp_size_o), .in_resp_data_o(w_in_resp_data_o),
    .in_resp_v_o(w_in_resp_v_o), .in_resp_yumi_i(w_in_resp_yumi_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  beat_t       exp_beats[$];
  resp_t       exp_resps[$];
  logic [31:0] rq[$];
  int          unans = 0;

  beat_t       w_exp_beats[$];
  resp_t       w_exp_resps[$];
  logic [31:0] w_rq[$];
  int          w_unans = 0;

  logic        toggle_rdy = 1'b0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void exp_beat(input logic [15:0] h, input logic [39:0] a,
                                   input logic [2:0] s, input logic [31:0] d);
    beat_t b;
    b.hdr = h; b.addr = a; b.size = s; b.data = d;
    exp_beats.push_back(b);
  endfunction

  function automatic void exp_resp(input logic [15:0] h, input logic [39:0] a,
                                   input logic [2:0] s, input logic [127:0] d);
    resp_t r;
    r.hdr = h; r.addr = a; r.size = s; r.data = d;
    exp_resps.push_back(r);
  endfunction

  // Monitor: handshakes are sampled on the falling edge, where inputs and
  // combinational outputs are stable ahead of the rising edge that commits them.
  beat_t mb;
  resp_t mr;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_cmd_v_o && out_cmd_ready_i) begin
        unans++;
        if (exp_beats.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat.extra: got beat addr 0x%0h, expected none", out_cmd_addr_o);
        end else begin
          mb = exp_beats.pop_front();
          chk("beat.hdr",  out_cmd_hdr_o,  mb.hdr);
          chk("beat.addr", out_cmd_addr_o, mb.addr);
          chk("beat.size", out_cmd_size_o, mb.size);
          chk("beat.data", out_cmd_data_o, mb.data);
        end
      end
      if (out_resp_yumi_o) begin
        if (rq.size() > 0) void'(rq.pop_front());
        unans--;
      end
      if (in_resp_v_o && in_resp_yumi_i) begin
        if (exp_resps.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp.extra: got resp data 0x%0h, expected none", in_resp_data_o);
        end else begin
          mr = exp_resps.pop_front();
          chk("resp.hdr",  in_resp_hdr_o,  mr.hdr);
          chk("resp.addr", in_resp_addr_o, mr.addr);
          chk("resp.size", in_resp_size_o, mr.size);
          chk("resp.data", in_resp_data_o, mr.data);
        end
      end
      if (w_out_cmd_v_o && w_out_cmd_ready_i) begin
        w_unans++;
        if (w_exp_beats.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wbeat.extra: got beat addr 0x%0h, expected none", w_out_cmd_addr_o);
        end else begin
          mb = w_exp_beats.pop_front();
          chk("wbeat.hdr",  w_out_cmd_hdr_o,  mb.hdr);
          chk("wbeat.addr", w_out_cmd_addr_o, mb.addr);
          chk("wbeat.size", w_out_cmd_size_o, mb.size);
          chk("wbeat.data", w_out_cmd_data_o, mb.data);
        end
      end
      if (w_out_resp_yumi_o) begin
        if (w_rq.size() > 0) void'(w_rq.pop_front());
        w_unans--;
      end
      if (w_in_resp_v_o && w_in_resp_yumi_i) begin
        if (w_exp_resps.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wresp.extra: got resp data 0x%0h, expected none", w_in_resp_data_o);
        end else begin
          mr = w_exp_resps.pop_front();
          chk("wresp.hdr",  w_in_resp_hdr_o,  mr.hdr);
          chk("wresp.addr", w_in_resp_addr_o, mr.addr);
          chk("wresp.size", w_in_resp_size_o, mr.size);
          chk("wresp.data", w_in_resp_data_o, mr.data);
        end
      end
    end
  end

  // Memory-side responder: answers beats in order once they have been sent.
  initial forever begin
    @(posedge clk);
    #1;
    out_resp_v_i      = (unans > 0) && (rq.size() > 0);
    out_resp_data_i   = (rq.size() > 0) ? rq[0] : 32'h0;
    w_out_resp_v_i    = (w_unans > 0) && (w_rq.size() > 0);
    w_out_resp_data_i = (w_rq.size() > 0) ? w_rq[0] : 32'h0;
    out_cmd_ready_i   = toggle_rdy ? ~out_cmd_ready_i : 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [15:0] h, input logic [39:0] a,
                       input logic [2:0] s, input logic [63:0] d);
    int g;
    in_cmd_hdr_i = h; in_cmd_addr_i = a; in_cmd_size_i = s; in_cmd_data_i = d;
    in_cmd_v_i = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_cmd_ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("issue.ready", in_cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
    in_cmd_v_i = 1'b0;
  endtask

  task automatic w_issue(input logic [15:0] h, input logic [39:0] a,
                         input logic [2:0] s, input logic [127:0] d);
    int g;
    w_in_cmd_hdr_i = h; w_in_cmd_addr_i = a; w_in_cmd_size_i = s; w_in_cmd_data_i = d;
    w_in_cmd_v_i = 1'b1;
    g = 0;
    @(negedge clk);
    while (!w_in_cmd_ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("wissue.ready", w_in_cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
    w_in_cmd_v_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while ((exp_beats.size() + exp_resps.size() + w_exp_beats.size() + w_exp_resps.size()) > 0
           && g < 400) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk({nm, ".pending"},
        exp_beats.size() + exp_resps.size() + w_exp_beats.size() + w_exp_resps.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    in_cmd_v_i = 1'b0; in_cmd_hdr_i = '0; in_cmd_addr_i = '0; in_cmd_size_i = '0; in_cmd_data_i = '0;
    w_in_cmd_v_i = 1'b0; w_in_cmd_hdr_i = '0; w_in_cmd_addr_i = '0; w_in_cmd_size_i = '0;
    w_in_cmd_data_i = '0;
    out_cmd_ready_i = 1'b1; out_resp_v_i = 1'b0; out_resp_data_i = '0; in_resp_yumi_i = 1'b1;
    w_out_cmd_ready_i = 1'b1; w_out_resp_v_i = 1'b0; w_out_resp_data_i = '0; w_in_resp_yumi_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_cmd_ready",  in_cmd_ready_o,   1'b0);
    chk("rst.out_cmd_v",     out_cmd_v_o,      1'b0);
    chk("rst.out_resp_yumi", out_resp_yumi_o,  1'b0);
    chk("rst.in_resp_v",     in_resp_v_o,      1'b0);
    chk("rst.w_in_cmd_ready", w_in_cmd_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.idle_ready", in_cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Two-beat write, ready held high; first response lands with the second send
    exp_beat(16'h00A1, 40'h1000, 3'd2, 32'hCCCCDDDD);
    exp_beat(16'h00A1, 40'h1004, 3'd2, 32'hAAAABBBB);
    rq.push_back(32'h00000001); rq.push_back(32'h00000002);
    exp_resp(16'h00A1, 40'h1000, 3'd3, 128'h00000002_00000001);
    issue(16'h00A1, 40'h1000, 3'd3, 64'hAAAA_BBBB_CCCC_DDDD);
    drain("A");

    // Two-beat read with the wide response held to check e_done behaviour
    in_resp_yumi_i = 1'b0;
    exp_beat(16'h00B2, 40'h1000, 3'd2, 32'h0);
    exp_beat(16'h00B2, 40'h1004, 3'd2, 32'h0);
    rq.push_back(32'h11111111); rq.push_back(32'h22222222);
    exp_resp(16'h00B2, 40'h1000, 3'd3, 128'h22222222_11111111);
    issue(16'h00B2, 40'h1000, 3'd3, 64'h0);
    g = 0;
    while (!in_resp_v_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("B.done_v", in_resp_v_o, 1'b1);
    repeat (2) @(negedge clk);
    chk("B.done_ready", in_cmd_ready_o, 1'b0);
    chk("B.hold_v", in_resp_v_o, 1'b1);
    @(posedge clk);
    #1;
    in_resp_yumi_i = 1'b1;
    drain("B");

    // Sub-beat size 1: single beat, response replicated
    exp_beat(16'h00C3, 40'h2002, 3'd1, 32'h1234BEEF);
    rq.push_back(32'h0000BEEF);
    exp_resp(16'h00C3, 40'h2002, 3'd1, 128'h0000BEEF_0000BEEF);
    issue(16'h00C3, 40'h2002, 3'd1, 64'h0000_0000_1234_BEEF);
    drain("C");

    // Size equal to the narrow width: still one beat, replicated
    exp_beat(16'h00E5, 40'h4004, 3'd2, 32'h87654321);
    rq.push_back(32'hCAFEF00D);
    exp_resp(16'h00E5, 40'h4004, 3'd2, 128'hCAFEF00D_CAFEF00D);
    issue(16'h00E5, 40'h4004, 3'd2, 64'hFFFF0000_87654321);
    drain("C2");

    // Toggling narrow ready
    toggle_rdy = 1'b1;
    exp_beat(16'h00D4, 40'h3008, 3'd2, 32'h77778888);
    exp_beat(16'h00D4, 40'h300C, 3'd2, 32'h55556666);
    rq.push_back(32'h9999AAAA); rq.push_back(32'hBBBBCCCC);
    exp_resp(16'h00D4, 40'h3008, 3'd3, 128'hBBBBCCCC_9999AAAA);
    issue(16'h00D4, 40'h3008, 3'd3, 64'h5555_6666_7777_8888);
    drain("D");
    toggle_rdy = 1'b0;
    @(posedge clk);
    #1;

    // Reset after the first beat is accepted: transaction is dropped
    exp_beat(16'h00F6, 40'h6000, 3'd2, 32'h33334444);
    rq.push_back(32'h0BAD0BAD);
    issue(16'h00F6, 40'h6000, 3'd3, 64'h1111_2222_3333_4444);
    g = 0;
    while (exp_beats.size() > 0 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("E.beat0_seen", exp_beats.size(), 0);
    @(posedge clk);
    #2;
    out_resp_v_i = 1'b0;
    rq.delete();
    unans = 0;
    rst_n = 1'b0;
    #1;
    chk("E.rst.in_cmd_ready",  in_cmd_ready_o,  1'b0);
    chk("E.rst.out_cmd_v",     out_cmd_v_o,     1'b0);
    chk("E.rst.out_resp_yumi", out_resp_yumi_o, 1'b0);
    chk("E.rst.in_resp_v",     in_resp_v_o,     1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("E.idle_ready", in_cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Fresh command after reset starts from beat 0
    exp_beat(16'h0007, 40'h7000, 3'd2, 32'h33334444);
    exp_beat(16'h0007, 40'h7004, 3'd2, 32'h11112222);
    rq.push_back(32'h5A5A5A5A); rq.push_back(32'hA5A5A5A5);
    exp_resp(16'h0007, 40'h7000, 3'd3, 128'hA5A5A5A5_5A5A5A5A);
    issue(16'h0007, 40'h7000, 3'd3, 64'h1111_2222_3333_4444);
    drain("F");

    // 128-bit wide side, size 4: four beats
    begin
      beat_t b;
      resp_t r;
      for (int k = 0; k < 4; k++) begin
        b.hdr = 16'h00C8; b.addr = 40'h8000 + 40'(4 * k); b.size = 3'd2;
        b.data = 32'h11111111 * (k + 1);
        w_exp_beats.push_back(b);
        w_rq.push_back(32'hA0000000 + 32'(k));
      end
      r.hdr = 16'h00C8; r.addr = 40'h8000; r.size = 3'd4;
      r.data = 128'hA0000003_A0000002_A0000001_A0000000;
      w_exp_resps.push_back(r);
    end
    w_issue(16'h00C8, 40'h8000, 3'd4, 128'h44444444_33333333_22222222_11111111);
    drain("G");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
